// File: rtl/pulse_stretcher_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pulse_stretcher_if                                              |
// | Brief    : Event/pulse signal bundle for pulse_stretcher                   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
interface pulse_stretcher_if #(
    parameter int QUEUE_DEPTH = 7
);
    localparam int c_PEND_W = $clog2(QUEUE_DEPTH + 1);

    logic                sig_event;
    logic                clr_ovf;
    logic                out;
    logic                busy;
    logic [c_PEND_W-1:0] pending;
    logic                overflow;

    modport master (
        output sig_event,
        output clr_ovf,
        input  out,
        input  busy,
        input  pending,
        input  overflow
    );

    modport slave (
        input  sig_event,
        input  clr_ovf,
        output out,
        output busy,
        output pending,
        output overflow
    );
endinterface
`default_nettype wire

// File: rtl/pulse_stretcher.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pulse_stretcher                                                 |
// | Brief    : Turns event strobes into fixed-width pulses with a low gap;     |
// |            STRETCH_QUEUE_EN enables queuing of events during a pulse.      |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module pulse_stretcher #(
    parameter int HIGH_CYCLES = 1000,
    parameter int LOW_CYCLES  = 1000,
    parameter int QUEUE_DEPTH = 7
) (
    input  wire logic        clk,
    input  wire logic        rst,
    pulse_stretcher_if.slave bus
);

    localparam int c_MAX_CYCLES = (HIGH_CYCLES > LOW_CYCLES) ? HIGH_CYCLES : LOW_CYCLES;
    localparam int c_CNT_W      = (c_MAX_CYCLES > 1) ? $clog2(c_MAX_CYCLES) : 1;
    localparam int c_PEND_W     = $clog2(QUEUE_DEPTH + 1);

    localparam logic [c_CNT_W-1:0] c_HIGH_LOAD = c_CNT_W'(HIGH_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_LOW_LOAD  = c_CNT_W'(LOW_CYCLES - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_HIGH = 2'd1;
    localparam logic [1:0] c_GAP  = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic               r_out;
    logic               w_out_nxt;
    logic               r_overflow;
    logic               w_overflow_nxt;

    logic               w_gap_done;
    logic               w_pend_nz;
    logic               w_direct;
    logic               w_enq_req;
    logic               w_ovf_set;

    assign w_gap_done = (r_state == c_GAP) && (r_cnt == '0);

    // An event starts a pulse directly only when nothing queued is ahead of it
    assign w_direct  = bus.sig_event &&
                       ((r_state == c_IDLE) || (w_gap_done && !w_pend_nz));
    assign w_enq_req = bus.sig_event && !w_direct;

`ifdef STRETCH_QUEUE_EN
    localparam logic [c_PEND_W-1:0] c_DEPTH = c_PEND_W'(QUEUE_DEPTH);

    logic [c_PEND_W-1:0] r_pending;
    logic [c_PEND_W-1:0] w_pending_nxt;
    logic                w_deq;
    logic                w_enq;

    assign w_pend_nz = (r_pending != '0);
    assign w_deq     = w_gap_done && w_pend_nz;
    // A dequeue on the same edge frees the slot, so a full queue still accepts
    assign w_ovf_set = w_enq_req && (r_pending == c_DEPTH) && !w_deq;
    assign w_enq     = w_enq_req && !w_ovf_set;

    always_comb begin
        w_pending_nxt = r_pending;
        case ({w_enq, w_deq})
            2'b10:   w_pending_nxt = r_pending + 1'b1;
            2'b01:   w_pending_nxt = r_pending - 1'b1;
            default: w_pending_nxt = r_pending;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending <= '0;
        end else begin
            r_pending <= w_pending_nxt;
        end
    end

    assign bus.pending = r_pending;
`else
    assign w_pend_nz   = 1'b0;
    assign w_ovf_set   = w_enq_req;
    assign bus.pending = {c_PEND_W{1'b0}};
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_IDLE;
            r_cnt      <= '0;
            r_out      <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_out      <= w_out_nxt;
            r_overflow <= w_overflow_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            c_IDLE: begin
                if (bus.sig_event) begin
                    w_state_nxt = c_HIGH;
                    w_cnt_nxt   = c_HIGH_LOAD;
                end
            end
            c_HIGH: begin
                if (r_cnt == '0) begin
                    w_state_nxt = c_GAP;
                    w_cnt_nxt   = c_LOW_LOAD;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            c_GAP: begin
                if (r_cnt == '0) begin
                    if (w_pend_nz || bus.sig_event) begin
                        w_state_nxt = c_HIGH;
                        w_cnt_nxt   = c_HIGH_LOAD;
                    end else begin
                        w_state_nxt = c_IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Output logic; out is registered from the upcoming state
    always_comb begin
        w_out_nxt      = (w_state_nxt == c_HIGH);
        w_overflow_nxt = r_overflow;
        if (w_ovf_set) begin
            w_overflow_nxt = 1'b1;
        end else if (bus.clr_ovf) begin
            w_overflow_nxt = 1'b0;
        end
    end

    assign bus.out      = r_out;
    assign bus.busy     = (r_state != c_IDLE);
    assign bus.overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_pulse_stretcher.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_pulse_stretcher                                              |
// | Brief    : Directed self-checking bench, HIGH=4 LOW=3 DEPTH=2              |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_pulse_stretcher;

`ifdef STRETCH_QUEUE_EN
    localparam bit c_Q = 1'b1;
`else
    localparam bit c_Q = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp  = 0;
    int   n_fail = 0;

    pulse_stretcher_if #(.QUEUE_DEPTH(2)) bus ();

    pulse_stretcher #(
        .HIGH_CYCLES (4),
        .LOW_CYCLES  (3),
        .QUEUE_DEPTH (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        bus.sig_event = 1'b0;
        bus.clr_ovf   = 1'b0;
        rst           = 1'b1;
        ticks(2);
        check("rst_out", bus.out, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_pending", bus.pending, 0);
        check("rst_overflow", bus.overflow, 0);
        rst = 1'b0;
        ticks(3);

        // Single event: high for 4 edges, low gap of 3, then idle
        bus.sig_event = 1'b1;
        tick();
        bus.sig_event = 1'b0;
        check("single_rise_out", bus.out, 1);
        check("single_rise_busy", bus.busy, 1);
        ticks(3);
        check("single_last_high", bus.out, 1);
        tick();
        check("single_fall_out", bus.out, 0);
        check("single_fall_busy", bus.busy, 1);
        ticks(2);
        check("single_gap_busy", bus.busy, 1);
        tick();
        check("single_idle_busy", bus.busy, 0);
        check("single_pending", bus.pending, 0);
        check("single_overflow", bus.overflow, 0);
        ticks(2);

        // Four back-to-back events with a depth-2 queue
        bus.sig_event = 1'b1;
        tick();
        check("burst_e0_pending", bus.pending, 0);
        tick();
        check("burst_e1_pending", bus.pending, c_Q ? 1 : 0);
        check("burst_e1_overflow", bus.overflow, c_Q ? 0 : 1);
        tick();
        check("burst_e2_pending", bus.pending, c_Q ? 2 : 0);
        tick();
        bus.sig_event = 1'b0;
        check("burst_e3_pending", bus.pending, c_Q ? 2 : 0);
        check("burst_e3_overflow", bus.overflow, 1);
        tick();
        check("burst_fall", bus.out, 0);
        ticks(3);
        check("burst_second_out", bus.out, c_Q ? 1 : 0);
        check("burst_second_pending", bus.pending, c_Q ? 1 : 0);
        check("burst_second_busy", bus.busy, c_Q ? 1 : 0);
        ticks(7);
        check("burst_third_out", bus.out, c_Q ? 1 : 0);
        check("burst_third_pending", bus.pending, 0);
        ticks(7);
        check("burst_idle_busy", bus.busy, 0);
        check("burst_idle_out", bus.out, 0);

        bus.clr_ovf = 1'b1;
        tick();
        bus.clr_ovf = 1'b0;
        check("clr_overflow", bus.overflow, 0);
        ticks(2);

        // Event on the final gap cycle starts the next pulse directly
        bus.sig_event = 1'b1;
        tick();
        bus.sig_event = 1'b0;
        ticks(6);
        check("direct_pre_out", bus.out, 0);
        check("direct_pre_busy", bus.busy, 1);
        bus.sig_event = 1'b1;
        tick();
        bus.sig_event = 1'b0;
        check("direct_out", bus.out, 1);
        check("direct_pending", bus.pending, 0);
        check("direct_overflow", bus.overflow, 0);
        ticks(7);
        check("direct_idle_busy", bus.busy, 0);
        ticks(2);

        // Set beats clear when an overflowing event coincides with clr_ovf
        bus.sig_event = 1'b1;
        ticks(3);
        bus.clr_ovf = 1'b1;
        tick();
        bus.sig_event = 1'b0;
        check("ovf_set_wins", bus.overflow, 1);
        tick();
        bus.clr_ovf = 1'b0;
        check("ovf_clear_alone", bus.overflow, 0);
        ticks(20);
        check("ovf_idle_busy", bus.busy, 0);
        check("ovf_idle_pending", bus.pending, 0);
        ticks(2);

        // Reset mid-pulse with a coincident event
        bus.sig_event = 1'b1;
        ticks(2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.sig_event = 1'b0;
        check("midrst_out", bus.out, 0);
        check("midrst_busy", bus.busy, 0);
        check("midrst_pending", bus.pending, 0);
        check("midrst_overflow", bus.overflow, 0);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("midrst_no_pulse", bus.out, 0);
        end
        check("midrst_busy_after", bus.busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
